// File: rtl/fab_cmd_host.sv
// Command initiator for the fib/fact unit: one command in flight, drives the s/op/in handshake and returns the result.
// Accept -> unit_s is 1 cycle; done -> unit_s low is 1 cycle; done low -> rsp_valid is 1 cycle; req_ready only in IDLE, rsp held until rsp_ready.
module fab_cmd_host #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_arg,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_err,
  output logic              unit_s,
  output logic [1:0]        unit_op,
  output logic [DATA_W-1:0] unit_in,
  input  logic [DATA_W-1:0] unit_out,
  input  logic              unit_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RELEASE,
    S_RESP
  } state_t;

  typedef struct packed {
    logic [1:0]        op;
    logic [DATA_W-1:0] arg;
  } cmd_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TO_ISS  = 2'b10;
  localparam logic [1:0] ERR_TO_REL  = 2'b11;
  localparam logic [1:0] OP_ILLEGAL  = 2'b11;

  // A phase lasts at most TIMEOUT cycles; the timer holds 0..TIMEOUT-1 during it.
  localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);

  state_t            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic              unit_s_q, unit_s_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]        rsp_err_q, rsp_err_d;
  logic [15:0]       timer_q, timer_d;
  logic              timed_out;

  assign timed_out = (timer_q >= TMAX);

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    unit_s_d    = unit_s_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    timer_d     = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_op == OP_ILLEGAL) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = ERR_ILLEGAL;
            rsp_data_d  = '0;
          end else begin
            state_d    = S_ISSUE;
            unit_s_d   = 1'b1;
            cmd_d      = '{op: req_op, arg: req_arg};
            rsp_err_d  = ERR_OK;
            rsp_data_d = '0;
          end
        end
      end
      S_ISSUE: begin
        // A done that is already high on entry is taken as the result.
        if (unit_done) begin
          rsp_data_d = unit_out;
          unit_s_d   = 1'b0;
          state_d    = S_RELEASE;
        end else if (timed_out) begin
          unit_s_d    = 1'b0;
          rsp_err_d   = ERR_TO_ISS;
          rsp_data_d  = '0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RELEASE: begin
        if (!unit_done) begin
          rsp_err_d   = ERR_OK;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (timed_out) begin
          rsp_err_d   = ERR_TO_REL;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      unit_s_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= ERR_OK;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      unit_s_q    <= unit_s_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      timer_q     <= timer_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign unit_s    = unit_s_q;
  assign unit_op   = cmd_q.op;
  assign unit_in   = cmd_q.arg;

endmodule
